// File: rtl/reg_wb_buffer.sv
// Writeback buffer: 2-entry in-order queue feeding the register file write port,
// with two forwarding lookups so decode never reads a stale register.
module reg_wb_buffer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned OP_W   = 3
) (
   input  logic              clk_50MHz,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              wb_hold,
   output logic [OP_W-1:0]   reg_op,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic [OP_W-1:0]   qa_op,
   input  logic [ADDR_W-1:0] qa_addr,
   output logic              qa_hit,
   output logic [DATA_W-1:0] qa_data,
   input  logic [OP_W-1:0]   qb_op,
   input  logic [ADDR_W-1:0] qb_addr,
   output logic              qb_hit,
   output logic [DATA_W-1:0] qb_data,
   output logic [1:0]        count
);

   // Register-op encodings shared with the register file decoder
   localparam logic [OP_W-1:0] REG_OP_NOP = OP_W'(0);
   localparam logic [OP_W-1:0] REG_OP_T   = OP_W'(1);
   localparam logic [OP_W-1:0] REG_OP_SP  = OP_W'(2);
   localparam logic [OP_W-1:0] REG_OP_IH  = OP_W'(3);
   localparam logic [OP_W-1:0] REG_OP_RA  = OP_W'(4);
   localparam logic [OP_W-1:0] REG_OP_REG = OP_W'(5);

   logic [OP_W-1:0]   ent_op   [2];
   logic [ADDR_W-1:0] ent_addr [2];
   logic [DATA_W-1:0] ent_data [2];
   logic              head;
   logic              tail;
   logic              push;
   logic              pop;
   logic              young;

   assign pop      = (count != 2'd0) && !wb_hold;
   assign in_ready = (count < 2'd2) || pop;
   assign push     = in_valid && in_ready && (in_op != REG_OP_NOP);
   assign young    = head ^ 1'b1;

   // Queue state
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            ent_op[i]   <= REG_OP_NOP;
            ent_addr[i] <= '0;
            ent_data[i] <= '0;
         end
      end else begin
         if (push) begin
            ent_op[tail]   <= in_op;
            ent_addr[tail] <= in_addr;
            ent_data[tail] <= in_data;
            tail           <= tail ^ 1'b1;
         end
         if (pop) head <= head ^ 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Write port shows the head only in the cycle it retires
   always_comb begin
      reg_op  = REG_OP_NOP;
      wb_addr = '0;
      wb_data = '0;
      if (pop) begin
         reg_op  = ent_op[head];
         wb_addr = ent_addr[head];
         wb_data = ent_data[head];
      end
   end

   function automatic logic entry_match(input logic [OP_W-1:0] eop,
                                        input logic [ADDR_W-1:0] eaddr,
                                        input logic [OP_W-1:0] qop,
                                        input logic [ADDR_W-1:0] qaddr);
      entry_match = (qop != REG_OP_NOP) && (eop == qop) &&
                    ((qop != REG_OP_REG) || (eaddr == qaddr));
   endfunction

   // Forwarding: head checked first, younger entry overrides
   always_comb begin
      qa_hit  = 1'b0;
      qa_data = '0;
      qb_hit  = 1'b0;
      qb_data = '0;
      if (count != 2'd0) begin
         if (entry_match(ent_op[head], ent_addr[head], qa_op, qa_addr)) begin
            qa_hit  = 1'b1;
            qa_data = ent_data[head];
         end
         if (entry_match(ent_op[head], ent_addr[head], qb_op, qb_addr)) begin
            qb_hit  = 1'b1;
            qb_data = ent_data[head];
         end
      end
      if (count == 2'd2) begin
         if (entry_match(ent_op[young], ent_addr[young], qa_op, qa_addr)) begin
            qa_hit  = 1'b1;
            qa_data = ent_data[young];
         end
         if (entry_match(ent_op[young], ent_addr[young], qb_op, qb_addr)) begin
            qb_hit  = 1'b1;
            qb_data = ent_data[young];
         end
      end
   end

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Directed bench for reg_wb_buffer: retirement order, full/hold handshake,
// forwarding priority, NOP drop and mid-operation reset.
module tb_reg_wb_buffer;

   localparam logic [2:0] NOP = 3'd0;
   localparam logic [2:0] T   = 3'd1;
   localparam logic [2:0] SP  = 3'd2;
   localparam logic [2:0] IH  = 3'd3;
   localparam logic [2:0] REG = 3'd5;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [2:0]  in_addr;
   logic [15:0] in_data;
   logic        wb_hold;
   logic [2:0]  reg_op;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [2:0]  qa_op, qb_op;
   logic [2:0]  qa_addr, qb_addr;
   logic        qa_hit, qb_hit;
   logic [15:0] qa_data, qb_data;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   reg_wb_buffer dut (
      .clk_50MHz(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_addr(in_addr), .in_data(in_data),
      .wb_hold(wb_hold),
      .reg_op(reg_op), .wb_addr(wb_addr), .wb_data(wb_data),
      .qa_op(qa_op), .qa_addr(qa_addr), .qa_hit(qa_hit), .qa_data(qa_data),
      .qb_op(qb_op), .qb_addr(qb_addr), .qb_hit(qb_hit), .qb_data(qb_data),
      .count(count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle inputs/outputs 1ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [2:0] op, input logic [2:0] a,
                        input logic [15:0] d);
      in_valid = v;
      in_op    = op;
      in_addr  = a;
      in_data  = d;
      #4;
   endtask

   task automatic port(input string tag, input logic [2:0] op, input logic [2:0] a,
                       input logic [15:0] d);
      check({tag, ".op"},   32'(reg_op),  32'(op));
      check({tag, ".addr"}, 32'(wb_addr), 32'(a));
      check({tag, ".data"}, 32'(wb_data), 32'(d));
   endtask

   task automatic qa_chk(input string tag, input logic h, input logic [15:0] d);
      check({tag, ".hit"},  32'(qa_hit),  32'(h));
      check({tag, ".data"}, 32'(qa_data), 32'(d));
   endtask

   task automatic qb_chk(input string tag, input logic h, input logic [15:0] d);
      check({tag, ".hit"},  32'(qb_hit),  32'(h));
      check({tag, ".data"}, 32'(qb_data), 32'(d));
   endtask

   initial begin
      rst = 1'b1; wb_hold = 1'b0;
      in_valid = 1'b0; in_op = NOP; in_addr = '0; in_data = '0;
      qa_op = REG; qa_addr = 3'd3; qb_op = SP; qb_addr = '0;
      tick();
      rst = 1'b0;
      #4;
      // Reset state
      port("rst", NOP, 3'd0, 16'h0);
      check("rst.ready", 32'(in_ready), 32'd1);
      check("rst.count", 32'(count), 32'd0);
      qa_chk("rst.qa", 1'b0, 16'h0);
      qb_chk("rst.qb", 1'b0, 16'h0);

      // Single push
      tick();
      offer(1'b1, REG, 3'd3, 16'h1234);
      check("single.ready", 32'(in_ready), 32'd1);
      port("single.empty", NOP, 3'd0, 16'h0);
      tick();
      offer(1'b0, NOP, 3'd0, 16'h0);
      port("single.wr", REG, 3'd3, 16'h1234);
      check("single.count1", 32'(count), 32'd1);
      qa_chk("single.fwd", 1'b1, 16'h1234);
      tick(); #4;
      port("single.after", NOP, 3'd0, 16'h0);
      check("single.count0", 32'(count), 32'd0);

      // Back-to-back stream with forwarding on {REG,5}
      qa_op = REG; qa_addr = 3'd5;
      tick();
      offer(1'b1, SP, 3'd6, 16'hBF00);
      qa_chk("stream.c0", 1'b0, 16'h0);
      tick();
      offer(1'b1, REG, 3'd5, 16'h0007);
      port("stream.w0", SP, 3'd6, 16'hBF00);
      qb_chk("stream.sp", 1'b1, 16'hBF00);
      qa_chk("stream.c1", 1'b0, 16'h0);
      tick();
      offer(1'b1, T, 3'd0, 16'h0001);
      port("stream.w1", REG, 3'd5, 16'h0007);
      qa_chk("stream.c2", 1'b1, 16'h0007);
      tick();
      offer(1'b0, NOP, 3'd0, 16'h0);
      port("stream.w2", T, 3'd0, 16'h0001);
      qa_chk("stream.c3", 1'b0, 16'h0);
      tick(); #4;
      check("stream.count", 32'(count), 32'd0);

      // Full with simultaneous push/pop
      tick();
      wb_hold = 1'b1;
      offer(1'b1, REG, 3'd1, 16'h1111);
      tick();
      offer(1'b1, REG, 3'd2, 16'h2222);
      check("full.ready1", 32'(in_ready), 32'd1);
      tick();
      offer(1'b0, NOP, 3'd0, 16'h0);
      check("full.count", 32'(count), 32'd2);
      check("full.ready0", 32'(in_ready), 32'd0);
      port("full.hold", NOP, 3'd0, 16'h0);
      tick();
      wb_hold = 1'b0;
      offer(1'b1, REG, 3'd4, 16'h3333);
      check("full.readyp", 32'(in_ready), 32'd1);
      port("full.wa", REG, 3'd1, 16'h1111);
      tick();
      offer(1'b0, NOP, 3'd0, 16'h0);
      check("full.count2", 32'(count), 32'd2);
      port("full.wb", REG, 3'd2, 16'h2222);
      tick(); #4;
      port("full.wc", REG, 3'd4, 16'h3333);
      tick(); #4;
      check("full.drain", 32'(count), 32'd0);

      // Youngest-wins forwarding
      tick();
      wb_hold = 1'b1;
      offer(1'b1, REG, 3'd2, 16'hAAAA);
      tick();
      offer(1'b1, REG, 3'd2, 16'hBBBB);
      tick();
      qa_op = REG; qa_addr = 3'd2; qb_op = REG; qb_addr = 3'd1;
      offer(1'b0, NOP, 3'd0, 16'h0);
      qa_chk("young.reg2", 1'b1, 16'hBBBB);
      qb_chk("young.reg1", 1'b0, 16'h0);
      qb_op = IH; qb_addr = 3'd2; #1;
      qb_chk("young.ih", 1'b0, 16'h0);
      qa_op = NOP; qa_addr = 3'd0; #1;
      qa_chk("young.nopq", 1'b0, 16'h0);
      qa_op = REG; qa_addr = 3'd2;

      // Reset mid-operation
      rst = 1'b1;
      tick();
      rst = 1'b0; #4;
      check("midrst.count", 32'(count), 32'd0);
      port("midrst.port", NOP, 3'd0, 16'h0);
      qa_chk("midrst.qa", 1'b0, 16'h0);
      wb_hold = 1'b0;
      tick(); #4;
      port("midrst.nostale", NOP, 3'd0, 16'h0);
      check("midrst.count2", 32'(count), 32'd0);

      // NOP input dropped, empty and non-empty
      offer(1'b1, NOP, 3'd7, 16'hFFFF);
      check("nop.ready", 32'(in_ready), 32'd1);
      tick();
      offer(1'b0, NOP, 3'd0, 16'h0);
      check("nop.count0", 32'(count), 32'd0);
      port("nop.nowr", NOP, 3'd0, 16'h0);
      wb_hold = 1'b1;
      offer(1'b1, REG, 3'd6, 16'h0055);
      tick();
      offer(1'b1, NOP, 3'd6, 16'hFFFF);
      check("nop.ready1", 32'(in_ready), 32'd1);
      tick();
      offer(1'b0, NOP, 3'd0, 16'h0);
      check("nop.count1", 32'(count), 32'd1);
      wb_hold = 1'b0; #1;
      port("nop.wr", REG, 3'd6, 16'h0055);
      tick(); #4;
      check("nop.drain", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
